uart_rx_ctrl: RTL and testbench

Receive-side controller for the UART datapath.
- Generates the 16x oversampling tick from `clk` and synchronises the `rx` line.
- Validates the start bit at mid-bit, then sequences data-bit and stop-bit sampling.
- Delivers each received byte through a valid/ready handshake, with framing-error and overrun reporting.
- Replaces the stand-alone start-bit detector with a complete, self-timed receive sequencer between the pad and the consumer logic.

---
 rtl/uart_rx_ctrl.sv | 150 +++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: 16x oversampled start/data/stop sequencing with a
// valid/ready byte output and framing-error / overrun pulses.
module uart_rx_ctrl #(
    parameter int unsigned CLK_DIV   = 27,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned      PreW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PreW-1:0]  PreMax  = PreW'(CLK_DIV - 1);
    localparam logic [3:0]       LastBit = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } state_t;

    state_t                 state;
    logic                   rx_m;
    logic                   rx_s;
    logic [PreW-1:0]        pre_cnt;
    logic                   os_tick;
    logic [3:0]             tick_cnt;
    logic [3:0]             bit_cnt;
    logic [DATA_BITS-1:0]   shreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (os_tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    assign os_tick = (pre_cnt == PreMax);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (valid && ready) begin
                valid <= 1'b0;
            end
            if (os_tick) begin
                case (state)
                    StIdle: begin
                        if (!rx_s) begin
                            state    <= StStart;
                            tick_cnt <= '0;
                            busy     <= 1'b1;
                        end
                    end
                    StStart: begin
                        if (tick_cnt == 4'd7) begin
                            if (!rx_s) begin
                                state    <= StData;
                                tick_cnt <= '0;
                                bit_cnt  <= '0;
                            end else begin
                                // Start bit gone by mid-bit: treat as a glitch.
                                state <= StIdle;
                                busy  <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                    StData: begin
                        if (tick_cnt == 4'd15) begin
                            shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
                            bit_cnt  <= bit_cnt + 4'd1;
                            tick_cnt <= '0;
                            if (bit_cnt == LastBit) begin
                                state <= StStop;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                    StStop: begin
                        if (tick_cnt == 4'd15) begin
                            tick_cnt <= '0;
                            if (rx_s) begin
                                state <= StIdle;
                                busy  <= 1'b0;
                                // A same-cycle accept frees the holding register.
                                if (!valid || ready) begin
                                    data  <= shreg;
                                    valid <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end else begin
                                frame_err <= 1'b1;
                                state     <= StWaitHigh;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                    StWaitHigh: begin
                        if (rx_s) begin
                            state <= StIdle;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at CLK_DIV=4, DATA_BITS=8 (64-cycle bit period).
module tb_uart_rx_ctrl;

    localparam int unsigned BitCyc = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int failures = 0;

    int   cyc = 0;
    int   busy_rises = 0;
    int   valid_rises = 0;
    int   fe_cycles = 0;
    int   ovr_cycles = 0;
    int   busy_rise_cyc = 0;
    int   valid_rise_cyc = 0;
    logic busy_q = 1'b0;
    logic valid_q = 1'b0;

    always #5 clk = ~clk;

    uart_rx_ctrl #(
        .CLK_DIV   (4),
        .DATA_BITS (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        busy_q  <= busy;
        valid_q <= valid;
        if (busy && !busy_q) begin
            busy_rises    <= busy_rises + 1;
            busy_rise_cyc <= cyc;
        end
        if (valid && !valid_q) begin
            valid_rises    <= valid_rises + 1;
            valid_rise_cyc <= cyc;
        end
        if (frame_err) fe_cycles <= fe_cycles + 1;
        if (overrun) ovr_cycles <= ovr_cycles + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_head(input logic [7:0] b);
        rx = 1'b0;
        idle(BitCyc);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(BitCyc);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_head(b);
        rx = stop;
        idle(BitCyc);
    endtask

    task automatic accept();
        ready = 1'b1;
        idle(1);
        ready = 1'b0;
    endtask

    initial begin
        int vr0;
        int fe0;
        int ov0;
        int br0;
        int target;

        rst   = 1'b1;
        rx    = 1'b1;
        ready = 1'b0;
        idle(3);
        check_val("rst_data", 32'(data), 32'h0);
        check_val("rst_valid", 32'(valid), 32'h0);
        check_val("rst_frame_err", 32'(frame_err), 32'h0);
        check_val("rst_overrun", 32'(overrun), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        idle(500);
        check_val("idle_busy_rises", 32'(busy_rises), 32'd0);
        check_val("idle_valid", 32'(valid), 32'h0);

        // Good frame, consumer not ready.
        send_frame(8'hA5, 1'b1);
        check_val("good_valid", 32'(valid), 32'h1);
        check_val("good_data", 32'(data), 32'hA5);
        check_val("good_fe", 32'(fe_cycles), 32'd0);
        check_val("good_latency", 32'(valid_rise_cyc - busy_rise_cyc), 32'd608);
        idle(20);
        check_val("good_hold", 32'(valid), 32'h1);
        accept();
        check_val("good_accept_valid", 32'(valid), 32'h0);
        check_val("good_accept_data", 32'(data), 32'hA5);

        // Glitch shorter than half a bit.
        vr0 = valid_rises;
        br0 = busy_rises;
        rx = 1'b0;
        idle(12);
        rx = 1'b1;
        idle(100);
        check_val("glitch_busy_pulse", 32'(busy_rises - br0), 32'd1);
        check_val("glitch_busy_now", 32'(busy), 32'h0);
        check_val("glitch_no_delivery", 32'(valid_rises - vr0), 32'd0);
        send_frame(8'h5A, 1'b1);
        check_val("glitch_next_valid", 32'(valid), 32'h1);
        check_val("glitch_next_data", 32'(data), 32'h5A);
        accept();

        // Framing error followed by a held-low line.
        vr0 = valid_rises;
        fe0 = fe_cycles;
        ov0 = ovr_cycles;
        send_frame(8'h3C, 1'b0);
        idle(200);
        check_val("fe_pulse", 32'(fe_cycles - fe0), 32'd1);
        check_val("fe_valid", 32'(valid), 32'h0);
        check_val("fe_busy_low_line", 32'(busy), 32'h1);
        rx = 1'b1;
        idle(20);
        check_val("fe_busy_released", 32'(busy), 32'h0);
        check_val("fe_single", 32'(fe_cycles - fe0), 32'd1);
        check_val("fe_no_delivery", 32'(valid_rises - vr0), 32'd0);
        check_val("fe_no_overrun", 32'(ovr_cycles - ov0), 32'd0);

        // Overrun: two frames back-to-back, nothing accepted.
        ov0 = ovr_cycles;
        fe0 = fe_cycles;
        send_frame(8'h11, 1'b1);
        check_val("ovr_first_valid", 32'(valid), 32'h1);
        check_val("ovr_first_data", 32'(data), 32'h11);
        send_frame(8'h22, 1'b1);
        check_val("ovr_pulse", 32'(ovr_cycles - ov0), 32'd1);
        check_val("ovr_data_kept", 32'(data), 32'h11);
        check_val("ovr_valid_kept", 32'(valid), 32'h1);
        check_val("ovr_no_fe", 32'(fe_cycles - fe0), 32'd0);
        accept();
        check_val("ovr_accept_valid", 32'(valid), 32'h0);

        // Same pair, ready asserted exactly at the second stop-sample edge.
        ov0 = ovr_cycles;
        send_frame(8'h11, 1'b1);
        check_val("ovr2_first_data", 32'(data), 32'h11);
        send_head(8'h22);
        rx = 1'b1;
        target = busy_rise_cyc + 607;
        for (int k = 0; k < 200 && cyc != target; k++) @(negedge clk);
        check_val("ovr2_align", 32'(cyc), 32'(target));
        ready = 1'b1;
        idle(1);
        ready = 1'b0;
        idle(40);
        check_val("ovr2_no_overrun", 32'(ovr_cycles - ov0), 32'd0);
        check_val("ovr2_data", 32'(data), 32'h22);
        check_val("ovr2_valid", 32'(valid), 32'h1);

        // Reset in the middle of the data bits; held byte is cleared too.
        vr0 = valid_rises;
        rx = 1'b0;
        idle(BitCyc * 4);
        rst = 1'b1;
        #1;
        check_val("mid_rst_busy", 32'(busy), 32'h0);
        check_val("mid_rst_valid", 32'(valid), 32'h0);
        check_val("mid_rst_data", 32'(data), 32'h0);
        rx = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(100);
        check_val("mid_rst_no_delivery", 32'(valid_rises - vr0), 32'd0);
        check_val("mid_rst_idle", 32'(busy), 32'h0);
        send_frame(8'h81, 1'b1);
        check_val("post_rst_valid", 32'(valid), 32'h1);
        check_val("post_rst_data", 32'(data), 32'h81);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
